// File: rtl/rfkit_dsp_pkg.sv
// Shared DSP definitions for the rfkit sample chain: the default sample type
// and the accumulator sizing helper used by the decimation blocks.
package rfkit_dsp_pkg;

    localparam int SampleBits = 12;

    typedef logic signed [SampleBits-1:0] sample_t;

    // Summing 2**log2_n signed words needs log2_n extra bits of headroom.
    function automatic int acc_width(input int word_bits, input int log2_n);
        return word_bits + log2_n;
    endfunction

endpackage

// File: rtl/boxcar_decimator.sv
// Boxcar decimator: averages each block of 2**DecimationLog2 accepted samples.
// Define BOXCAR_DECIMATOR_ROUND_EN to round half up instead of flooring.
module boxcar_decimator
    import rfkit_dsp_pkg::*;
#(
    parameter int WordLengthBits = 12,
    parameter int DecimationLog2 = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic signed [WordLengthBits-1:0] in,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic signed [WordLengthBits-1:0] out,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int AccBits = acc_width(WordLengthBits, DecimationLog2);
    localparam logic [DecimationLog2-1:0] CountLast = '1;
    localparam logic [DecimationLog2-1:0] CountStep = DecimationLog2'(1);

    logic signed [AccBits-1:0]        acc;
    logic        [DecimationLog2-1:0] count;
    logic signed [AccBits-1:0]        in_ext;
    logic signed [AccBits-1:0]        sum;
    logic signed [AccBits-1:0]        rounded;
    logic signed [WordLengthBits-1:0] scaled;
    logic                             accept;
    logic                             dump;

    // A full output register stalls the input unless it is drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign dump     = accept && (count == CountLast);

    always_comb begin
        in_ext = {{DecimationLog2{in[WordLengthBits-1]}}, in};
        sum    = acc + in_ext;
`ifdef BOXCAR_DECIMATOR_ROUND_EN
        rounded = sum + AccBits'(1 << (DecimationLog2 - 1));
`else
        rounded = sum;
`endif
        // The mean of N words of WordLengthBits always fits back into WordLengthBits.
        scaled = WordLengthBits'(rounded >>> DecimationLog2);
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            count     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                if (dump) begin
                    acc   <= '0;
                    count <= '0;
                    out   <= scaled;
                end else begin
                    acc   <= sum;
                    count <= count + CountStep;
                end
            end
            if (dump) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_boxcar_decimator.sv
// Self-checking bench for boxcar_decimator (12-bit words, decimation by 4)
// using a reference model and a result scoreboard queue.
module tb_boxcar_decimator;
    import rfkit_dsp_pkg::*;

    localparam int W = 12;
    localparam int L = 2;
    localparam int N = 1 << L;

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    sample_t din;
    logic    in_valid;
    logic    in_ready;
    sample_t dout;
    logic    out_valid;
    logic    out_ready;

    always #5 clk = ~clk;

    boxcar_decimator #(
        .WordLengthBits(W),
        .DecimationLog2(L)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (din),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out      (dout),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    int total = 0;
    int bad   = 0;

    int exp_q[$];
    int m_acc;
    int m_cnt;
    bit m_ov;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int scale(input int s);
        int r;
        r = s;
`ifdef BOXCAR_DECIMATOR_ROUND_EN
        r = r + (1 << (L - 1));
`endif
        return r >>> L;
    endfunction

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_ov  = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle: drive at the falling edge, check after the next one.
    task automatic step(input bit v, input int d, input bit ordy, output bit accepted);
        bit rdy;
        bit dump;
        in_valid  = v;
        din       = sample_t'(d);
        out_ready = ordy;
        #1;
        rdy = !m_ov || ordy;
        check("in_ready", int'(in_ready), int'(rdy));
        accepted = v && rdy;
        dump     = 1'b0;
        if (m_ov && ordy && exp_q.size() > 0) void'(exp_q.pop_front());
        if (accepted) begin
            if (m_cnt == N - 1) begin
                exp_q.push_back(scale(m_acc + d));
                m_acc = 0;
                m_cnt = 0;
                dump  = 1'b1;
            end else begin
                m_acc += d;
                m_cnt++;
            end
        end
        if (dump) m_ov = 1'b1;
        else if (ordy) m_ov = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("out_valid", int'(out_valid), int'(m_ov));
        if (m_ov) check("out", int'(dout), (exp_q.size() > 0) ? exp_q[0] : 99999);
    endtask

    task automatic idle(input int cycles);
        bit a;
        for (int i = 0; i < cycles; i++) step(1'b0, 0, 1'b1, a);
    endtask

    task automatic send(input int d);
        bit a;
        int n;
        n = 0;
        do begin
            step(1'b1, d, 1'b1, a);
            n++;
        end while (!a && n < 50);
        check("send_accept", int'(a), 1);
    endtask

    task automatic reset_pulse();
        rst      = 1'b0;
        in_valid = 1'b0;
        model_clear();
        #1;
        check("pulse_out", int'(dout), 0);
        check("pulse_out_valid", int'(out_valid), 0);
        check("pulse_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit a;
        int acc_cnt;
        int guard;

        // Long reset with a live-looking input that must be ignored.
        model_clear();
        in_valid  = 1'b1;
        din       = sample_t'(12'hAAA);
        out_ready = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            check("rst_out", int'(dout), 0);
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_in_ready", int'(in_ready), 1);
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        idle(1);

        for (int i = 0; i < 4; i++) send(15);
        idle(2);

        send(-12); send(-12); send(-12); send(-13);
        idle(1);

        for (int i = 0; i < 4; i++) send(2047);
        idle(1);
        for (int i = 0; i < 4; i++) send(-2048);
        idle(1);

        // Backpressure: the first result blocks further input until drained.
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 100, 1'b0, a);
            if (a) acc_cnt++;
        end
        check("bp_accepts_stalled", acc_cnt, 4);
        guard = 0;
        while (acc_cnt < 8 && guard < 50) begin
            step(1'b1, 100, 1'b1, a);
            if (a) acc_cnt++;
            guard++;
        end
        check("bp_accepts_total", acc_cnt, 8);
        idle(2);

        // Partial block is dropped by a mid-block reset.
        send(500); send(500);
        reset_pulse();
        for (int i = 0; i < 4; i++) send(100);
        idle(2);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)) - 2048,
                 ($urandom_range(0, 3) != 0), a);
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boxcar_decimator.md
BOXCAR_DECIMATOR -- requirements
Module: boxcar_decimator

Interface
REQ-001 SHALL have parameter WordLengthBits, default 12, signed sample width of in and out.
REQ-002 SHALL have parameter DecimationLog2, default 2, with decimation factor N = 2**DecimationLog2; legal range 1..8.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in  input  WordLengthBits  signed sample, typically gain_bit_shift's out.
REQ-006 SHALL have port in_valid  input  1  in holds a valid sample.
REQ-007 SHALL have port in_ready  output  1  block accepts in this cycle.
REQ-008 SHALL have port out  output  WordLengthBits  signed mean of the last N accepted samples.
REQ-009 SHALL have port out_valid  output  1  out holds an unconsumed result.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out this cycle.

Function
REQ-011 SHALL accept a sample on any rising edge where in_valid and in_ready are both 1.
REQ-012 SHALL drive in_ready = (not out_valid) or out_ready, combinationally.
REQ-013 SHALL hold a signed accumulator of WordLengthBits+DecimationLog2 bits and a count of 0..N-1; count only changes on accepts.
REQ-014 On an accept with count < N-1: accumulator += in; count += 1.
REQ-015 On an accept with count = N-1: load out with (accumulator + in) scaled per REQ-023/024; set out_valid; clear accumulator and count to 0.
REQ-016 Latency SHALL be one cycle: out_valid rises on the edge that accepts the Nth sample.
REQ-017 out_valid SHALL clear on an edge with out_ready = 1 and no simultaneous dump.
REQ-018 On an edge that both consumes out and dumps a new result, out_valid SHALL stay 1 and out SHALL take the new result.
REQ-019 out and out_valid SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-020 Scaled result SHALL always fit WordLengthBits; no saturation logic is required.

Reset
REQ-021 While rst = 0: out = 0, out_valid = 0, accumulator = 0, count = 0; in_ready = 1.
REQ-022 A reset mid-block SHALL discard any partial sum; the first post-reset dump uses only post-reset samples.

Configuration
REQ-023 With macro BOXCAR_DECIMATOR_ROUND_EN defined, out SHALL be (sum + 2**(DecimationLog2-1)) arithmetically shifted right by DecimationLog2 (round half toward +infinity).
REQ-024 Without BOXCAR_DECIMATOR_ROUND_EN, out SHALL be sum arithmetically shifted right by DecimationLog2 (floor).

Structure
REQ-025 Shared package rfkit_dsp_pkg SHALL hold the sample typedef and the accumulator-width helper function; the module imports it.
REQ-026 Block SHALL be a single module, boxcar_decimator, with no sub-modules.

Verification (WordLengthBits=12, DecimationLog2=2, out_ready=1 unless stated)
REQ-027 Reset held for 1000 cycles with in=0xAAA, in_valid=1 -> out=0, out_valid=0, in_ready=1 throughout.
REQ-028 Accept 15,15,15,15 on consecutive cycles -> out=15, out_valid=1 for exactly one cycle after the 4th accept.
REQ-029 Accept -12,-12,-12,-13 (sum -49) -> out=-12 with ROUND_EN, -13 without.
REQ-030 Accept 2047 x4 -> 2047; accept -2048 x4 -> -2048 (both modes, no wrap).
REQ-031 Backpressure: out_ready=0, 8 samples of 100 offered -> first dump holds out=100, out_valid=1, in_ready=0, count frozen; raise out_ready -> consumed; remaining samples produce a second 100.
REQ-032 Accept 500,500, pulse rst low one cycle, then accept 100 x4 -> single result out=100.
